asmd_param_counter_flagger: RTL
===============================

Name: asmd_param_counter_flagger

Overview:
Parametrised successor to the three-state Start/A/E/F counter-flagger used in the ASMD design examples, with the controller and datapath inside one block. On start it clears counter A and flag F, then increments A every cycle while E tracks a selectable bit of A. The stop condition is a runtime-loaded bit mask rather than fixed bits. Adds abort, auto-restart mode, busy/done handshake and a completed-run counter; intended as the drop-in core for the next-generation design examples and the synthesis flow.

Parameters:
WIDTH, 4, counter A width in bits (>=2)
E_BIT, 2, index of A bit that E samples (0..WIDTH-1)
RUN_W, 8, width of completed-run counter runs

Ports:
clock  input  1  rising-edge clock
reset_b  input  1  asynchronous active-low reset
start  input  1  begin a run; sampled only in IDLE
stop_mask  input  WIDTH  stop pattern; captured into smask when start is accepted
auto_restart  input  1  1: after FLAG, restart counting immediately; sampled in FLAG
abort  input  1  terminate a run in COUNT
A  output  WIDTH  counter value
E  output  1  registered copy of A[E_BIT], taken before increment
F  output  1  run-complete flag
busy  output  1  1 in COUNT or FLAG
done  output  1  1 for exactly the FLAG cycle (Moore)
runs  output  RUN_W  completed runs since reset; saturates at all-ones

Behaviour:
- Reset (async, reset_b=0): state=IDLE, A=0, E=0, F=0, smask=0, runs=0. All outputs are registered or state-decoded, so busy=0 and done=0. Reset mid-run aborts immediately with no F set.
- States: IDLE, COUNT, FLAG. All encodings are internal.
- IDLE: busy=0.
  - On start=1: A<=0, F<=0, smask<=stop_mask, go to COUNT.
  - E holds its value. With start=0, all registers hold.
- COUNT: busy=1. Priority order:
  - abort=1: go to IDLE. A, E and F hold (no increment that cycle).
  - Otherwise: A<=A+1 modulo 2^WIDTH (wraps silently), and E<=A[E_BIT] using the pre-increment A.
  - If (A & smask)==smask on the pre-increment A, go to FLAG; otherwise stay in COUNT.
  - smask=0 matches on the first COUNT cycle, giving exactly one increment.
  - start is ignored.
- FLAG: busy=1, done=1. F<=1. runs<=runs+1, saturating. abort and start are ignored.
  - If auto_restart=1: A<=0, go to COUNT, smask is retained, and F stays 1 through the next run.
  - Otherwise: go to IDLE, A holds.
- Latency: with the start edge at cycle 0, the run makes N COUNT cycles, where N = (first A value from 0 satisfying the mask) + 1. done is high for the single cycle after the last COUNT cycle.
- E: updates only in COUNT. It is never cleared by start.
- F: cleared only by an accepted start or by reset.

Test Plan:
- Baseline: WIDTH=4, E_BIT=2, stop_mask=4'b1100, one-cycle start -> 13 COUNT cycles (A evaluated 0..12), then FLAG. Final A=13, E=1, F=1, done high 1 cycle, runs=1, busy high 14 cycles, then IDLE.
- E tracking: same run -> E after each COUNT edge equals bit2 of 0,1,...,12, i.e. 0,0,0,0,1,1,1,1,0,0,0,0,1.
- Wrap: stop_mask=4'b1111 -> 16 COUNT cycles, A wraps 15->0, E=1, F=1, final A=0.
- Abort: stop_mask=4'b1100, abort asserted on the 5th COUNT cycle (A=4) -> IDLE next cycle, A=4 held, F=0, done never asserted, runs unchanged. A later start then runs normally.
- Auto-restart: stop_mask=4'b0011, auto_restart=1 for 3 runs -> each run has 4 COUNT cycles (A 0..3) plus 1 FLAG. done pulses every 5 cycles, runs 1,2,3, F stays 1. auto_restart=0 on the 3rd FLAG -> IDLE with A=4.
- Edge cases:
  - start during COUNT is ignored.
  - Asserting reset_b=0 mid-COUNT clears all outputs asynchronously, without a clock edge.
  - stop_mask=0 gives exactly one increment, then FLAG.
  - runs saturates at 255 when RUN_W=8.

Source files
------------

// File: rtl/asmd_param_counter_flagger.sv
// asmd_param_counter_flagger
// Controller and datapath of the Start/A/E/F counter-flagger in one block.
// A run clears A and F, then increments A every cycle while E samples
// A[E_BIT] (pre-increment). The run ends when every bit set in the captured
// stop mask is also set in A. FLAG raises F, counts the completed run and
// either returns to IDLE or restarts counting from zero.

module asmd_param_counter_flagger #(
    parameter int WIDTH = 4,
    parameter int E_BIT = 2,
    parameter int RUN_W = 8
) (
    input  logic             clock,
    input  logic             reset_b,
    input  logic             start,
    input  logic [WIDTH-1:0] stop_mask,
    input  logic             auto_restart,
    input  logic             abort,
    output logic [WIDTH-1:0] A,
    output logic             E,
    output logic             F,
    output logic             busy,
    output logic             done,
    output logic [RUN_W-1:0] runs
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        FLAG  = 2'b10
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] smask;
    logic             mask_hit;

    // Completed-run counter increments but sticks at all-ones.
    function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] value);
        logic [RUN_W-1:0] result;
        if (value == {RUN_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + RUN_W'(1);
        end
        return result;
    endfunction

    // Stop condition is evaluated on the pre-increment value of A.
    assign mask_hit = ((A & smask) == smask);

    // State register.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort outranks the stop condition in COUNT.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (mask_hit) begin
                    state_next = FLAG;
                end
            end
            FLAG: begin
                if (auto_restart) begin
                    state_next = COUNT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                done = 1'b0;
            end
            COUNT: begin
                busy = 1'b1;
                done = 1'b0;
            end
            FLAG: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath registers: A, E, F, captured stop mask and run counter.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            A     <= '0;
            E     <= 1'b0;
            F     <= 1'b0;
            smask <= '0;
            runs  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // E is deliberately left alone on start.
                    if (start) begin
                        A     <= '0;
                        F     <= 1'b0;
                        smask <= stop_mask;
                    end
                end
                COUNT: begin
                    // Aborting freezes A and E for that cycle.
                    if (!abort) begin
                        A <= A + WIDTH'(1);
                        E <= A[E_BIT];
                    end
                end
                FLAG: begin
                    F    <= 1'b1;
                    runs <= sat_inc(runs);
                    // Restart keeps smask and leaves F set for the next run.
                    if (auto_restart) begin
                        A <= '0;
                    end
                end
                default: begin
                    A <= A;
                end
            endcase
        end
    end

endmodule
